// File: rtl/mac_layer_seq.sv
// Sequences a shared 8x8 signed MAC through one fully-connected layer: clear, stream, drain, scale, write.
// Optional macro RELU_EN: clamp the scaled result to [0,127] instead of signed saturation to [-128,127].
module mac_layer_seq #(
  parameter int N_IN   = 784,
  parameter int N_OUT  = 32,
  parameter int IN_AW  = 10,
  parameter int WT_AW  = 15,
  parameter int OUT_AW = 5,
  parameter int SHIFT  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [25:0]       mac_acc,
  output logic              mac_clr_n,
  output logic [IN_AW-1:0]  in_addr,
  output logic [WT_AW-1:0]  wt_addr,
  output logic [OUT_AW-1:0] out_addr,
  output logic [7:0]        out_data,
  output logic              out_we,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ACC   = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [IN_AW-1:0]    i_q, i_d;
  logic [OUT_AW-1:0]   n_q, n_d;
  logic [WT_AW-1:0]    wt_q, wt_d;
  logic [7:0]          out_data_q, out_data_d;
  logic signed [25:0]  acc_shifted;
  logic [7:0]          sat_val;

  assign acc_shifted = $signed(mac_acc) >>> SHIFT;

  always_comb begin
    sat_val = acc_shifted[7:0];
`ifdef RELU_EN
    if (acc_shifted < 26'sd0) begin
      sat_val = 8'h00;
    end else if (acc_shifted > 26'sd127) begin
      sat_val = 8'h7F;
    end
`else
    if (acc_shifted > 26'sd127) begin
      sat_val = 8'h7F;
    end else if (acc_shifted < -26'sd128) begin
      sat_val = 8'h80;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      i_q        <= '0;
      n_q        <= '0;
      wt_q       <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      n_q        <= n_d;
      wt_q       <= wt_d;
      out_data_q <= out_data_d;
    end
  end

  // Weight address is a running counter: after the last input of neuron n it
  // sits at n*N_IN+N_IN-1, so one more increment lands on neuron n+1's row.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    n_d        = n_q;
    wt_d       = wt_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          i_d     = '0;
          n_d     = '0;
          wt_d    = '0;
        end
      end
      S_LOAD: begin
        state_d = S_ACC;
        i_d     = i_q + 1'b1;
        wt_d    = wt_q + 1'b1;
      end
      S_ACC: begin
        if (i_q == IN_AW'(N_IN - 1)) begin
          state_d = S_DRAIN;
        end else begin
          i_d  = i_q + 1'b1;
          wt_d = wt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        state_d = S_WRITE;
      end
      S_WRITE: begin
        out_data_d = sat_val;
        if (n_q == OUT_AW'(N_OUT - 1)) begin
          state_d = S_FIN;
        end else begin
          state_d = S_LOAD;
          n_d     = n_q + 1'b1;
          i_d     = '0;
          wt_d    = wt_q + 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mac_clr_n = (state_q == S_ACC) || (state_q == S_DRAIN);
    busy      = (state_q == S_LOAD) || (state_q == S_ACC) ||
                (state_q == S_DRAIN) || (state_q == S_WRITE);
    done      = (state_q == S_FIN);
    out_we    = (state_q == S_WRITE);
    out_data  = (state_q == S_WRITE) ? sat_val : out_data_q;
    out_addr  = n_q;
    in_addr   = i_q;
    wt_addr   = wt_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mac_layer_seq.sv
// Bench for mac_layer_seq: two instances (SHIFT=0 and SHIFT=7) driven in lockstep over behavioural MAC/RAM models.
// Handshake: start is a one-cycle pulse sampled on posedge; each out_we is one result popped from the expected queue.
module tb_mac_layer_seq;

  localparam int N_IN = 4;
  localparam int N_OUT = 2;

  logic clk;
  logic rst_n;
  logic start;

  logic signed [7:0] in_mem [N_IN];
  logic signed [7:0] wt_mem [N_IN*N_OUT];

  logic [25:0] acc0, acc7;
  logic        clr0, clr7;
  logic [1:0]  in_addr0, in_addr7;
  logic [2:0]  wt_addr0, wt_addr7;
  logic        out_addr0, out_addr7;
  logic [7:0]  out_data0, out_data7;
  logic        out_we0, out_we7;
  logic        busy0, busy7;
  logic        done0, done7;
  logic [2:0]  dbg0, dbg7;

  logic signed [7:0]  in_rd0, wt_rd0, in_rd7, wt_rd7;
  logic signed [15:0] prod0, prod7;

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] exp_q0[$];
  logic [8:0] exp_q7[$];

  mac_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_AW(2), .WT_AW(3), .OUT_AW(1), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mac_acc(acc0), .mac_clr_n(clr0),
    .in_addr(in_addr0), .wt_addr(wt_addr0), .out_addr(out_addr0), .out_data(out_data0),
    .out_we(out_we0), .busy(busy0), .done(done0), .dbg_state(dbg0)
  );

  mac_layer_seq #(.N_IN(N_IN), .N_OUT(N_OUT), .IN_AW(2), .WT_AW(3), .OUT_AW(1), .SHIFT(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .start(start), .mac_acc(acc7), .mac_clr_n(clr7),
    .in_addr(in_addr7), .wt_addr(wt_addr7), .out_addr(out_addr7), .out_data(out_data7),
    .out_we(out_we7), .busy(busy7), .done(done7), .dbg_state(dbg7)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read RAMs feeding a MAC with synchronous active-low clear
  always_comb begin
    prod0 = in_rd0 * wt_rd0;
    prod7 = in_rd7 * wt_rd7;
  end

  initial begin
    acc0 = '0;
    acc7 = '0;
  end

  always @(posedge clk) begin
    in_rd0 <= in_mem[in_addr0];
    wt_rd0 <= wt_mem[wt_addr0];
    in_rd7 <= in_mem[in_addr7];
    wt_rd7 <= wt_mem[wt_addr7];
    acc0   <= clr0 ? acc0 + 26'(prod0) : 26'd0;
    acc7   <= clr7 ? acc7 + 26'(prod7) : 26'd0;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_out(input int sh, input int n);
    int s;
    s = 0;
    for (int i = 0; i < N_IN; i++) s += int'(in_mem[i]) * int'(wt_mem[n*N_IN+i]);
    s = s >>> sh;
`ifdef RELU_EN
    if (s < 0) s = 0;
`else
    if (s < -128) s = -128;
`endif
    if (s > 127) s = 127;
    return s[7:0];
  endfunction

  task automatic load_mem(input int i0, input int i1, input int i2, input int i3, input int w0, input int w1);
    in_mem[0] = 8'(i0); in_mem[1] = 8'(i1); in_mem[2] = 8'(i2); in_mem[3] = 8'(i3);
    for (int k = 0; k < N_IN; k++) begin
      wt_mem[k]        = 8'(w0);
      wt_mem[N_IN + k] = 8'(w1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_state"}, 32'(dbg0), 32'd0);
    check_eq({tag, "_clr_n"}, 32'(clr0), 32'd0);
    check_eq({tag, "_addrs"}, {in_addr0, wt_addr0, out_addr0}, 32'd0);
    check_eq({tag, "_out_data"}, 32'(out_data0), 32'd0);
    check_eq({tag, "_we_busy_done"}, {out_we0, busy0, done0, out_we7, busy7, done7}, 32'd0);
  endtask

  // Driver: one layer run, called at a negedge; scoreboard pops on each write
  task automatic run_layer(input bit mid_start);
    int writes;
    int dones;
    logic [8:0] e;
    writes = 0;
    dones = 0;
    for (int n = 0; n < N_OUT; n++) begin
      exp_q0.push_back({1'(n), model_out(0, n)});
      exp_q7.push_back({1'(n), model_out(7, n)});
    end
    start = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start = mid_start && (cyc == 3);
      if (cyc == 1) check_eq("busy_after_start", 32'(busy0), 32'd1);
      if (out_we0) begin
        writes++;
        check_eq("write_cycle", cyc, (writes == 1) ? 32'd6 : 32'd12);
        if (exp_q0.size() == 0) check_eq("unexpected_write0", 32'd1, 32'd0);
        else begin
          e = exp_q0.pop_front();
          check_eq("result_shift0", {out_addr0, out_data0}, 32'(e));
        end
      end
      if (out_we7) begin
        if (exp_q7.size() == 0) check_eq("unexpected_write7", 32'd1, 32'd0);
        else begin
          e = exp_q7.pop_front();
          check_eq("result_shift7", {out_addr7, out_data7}, 32'(e));
        end
      end
      if (done0) begin
        dones++;
        check_eq("done_cycle", cyc, 32'd13);
        check_eq("busy_at_done", 32'(busy0), 32'd0);
      end
    end
    check_eq("write_count", writes, 32'd2);
    check_eq("done_count", dones, 32'd1);
    check_eq("queue_drained", exp_q0.size() + exp_q7.size(), 32'd0);
    exp_q0.delete();
    exp_q7.delete();
  endtask

  initial begin
    int stray_we;
    rst_n = 1'b0;
    start = 1'b0;
    load_mem(1, 2, 3, 4, 1, 1);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_after_reset", {busy0, done0, out_we0}, 32'd0);

    load_mem(1, 2, 3, 4, 1, 1);
    run_layer(1'b0);
    load_mem(1, 2, 3, 4, 1, 2);
    run_layer(1'b0);
    load_mem(127, 127, 127, 127, 127, 127);
    run_layer(1'b0);
    load_mem(1, 2, 3, 4, -1, -1);
    run_layer(1'b0);
    load_mem(-128, -128, -128, -128, -128, 127);
    run_layer(1'b0);
    load_mem(1, 2, 3, 4, 1, 2);
    run_layer(1'b1);

    // Asynchronous reset during neuron 0 accumulation
    load_mem(5, 6, 7, 8, 3, -3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("in_acc_before_reset", 32'(dbg0), 32'd2);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    stray_we = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_we0 || done0) stray_we++;
    end
    check_eq("no_write_in_reset", stray_we, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_layer(1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N_IN; k++) in_mem[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < N_IN*N_OUT; k++) wt_mem[k] = 8'($urandom_range(0, 255));
      run_layer(r[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
